// File: rtl/oam_dma_arbiter_pkg.sv
// Shared types and constants for the OAM DMA arbiter.
//   dma_state_t        : arbiter FSM states (IDLE, HALT, ALIGN, READ, WRITE)
//   DMA_REG_ADDR_DEF   : default CPU address whose write launches a DMA
//   OAM_DATA_ADDR_DEF  : default PPU OAM data port written by the DMA
package oam_dma_arbiter_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    localparam logic [ADDR_W-1:0] DMA_REG_ADDR_DEF  = 16'h4014;
    localparam logic [ADDR_W-1:0] OAM_DATA_ADDR_DEF = 16'h2004;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

endpackage

// File: rtl/oam_dma_arbiter.sv
// OAM DMA arbiter: shares one memory bus between the CPU and a 256-byte
// sprite DMA (page -> OAM data port). A CPU write to DMA_REG_ADDR stalls the
// CPU, then the arbiter copies {page,00..FF} to OAM_DATA_ADDR one byte per
// READ/WRITE pair.
// Build option: define OAM_DMA_ALIGN_EN to insert one ALIGN cycle when the
// HALT cycle lands on an odd clock (514-cycle stall instead of 513).
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   cpu_addr/read/write/wdata -> CPU request; cpu_rdata, cpu_rdy -> CPU
//   bus_addr/read/write/wdata -> shared bus; bus_rdata <- shared bus
//   dma_busy          : high whenever the FSM is not IDLE
module oam_dma_arbiter
    import oam_dma_arbiter_pkg::*;
#(
    parameter logic [ADDR_W-1:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
    parameter logic [ADDR_W-1:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rdy,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_read,
    output logic              bus_write,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              dma_busy
);

    dma_state_t        state;
    dma_state_t        state_next;
    logic [DATA_W-1:0] page;
    logic [DATA_W-1:0] count;
    logic [DATA_W-1:0] latch;
    logic              trigger;

    // Only meaningful in IDLE; all CPU inputs are ignored elsewhere.
    assign trigger   = cpu_write && (cpu_addr == DMA_REG_ADDR);
    assign cpu_rdata = bus_rdata;

`ifdef OAM_DMA_ALIGN_EN
    logic parity;

    // Free-running even/odd cycle marker used to decide on the ALIGN cycle.
    always_ff @(posedge clk) begin
        if (!rst) parity <= 1'b0;
        else      parity <= ~parity;
    end
`endif

    // State register and DMA datapath.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            page  <= '0;
            count <= '0;
            latch <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && trigger) begin
                page  <= cpu_wdata;
                count <= '0;
            end
            if (state == READ)  latch <= bus_rdata;
            if (state == WRITE) count <= count + DATA_W'(1);
        end
    end

    // Next-state logic and bus mux.
    always_comb begin
        state_next = state;
        bus_addr   = '0;
        bus_read   = 1'b0;
        bus_write  = 1'b0;
        bus_wdata  = '0;
        cpu_rdy    = 1'b0;
        dma_busy   = 1'b1;
        case (state)
            IDLE: begin
                bus_addr  = cpu_addr;
                bus_read  = cpu_read;
                bus_write = cpu_write;
                bus_wdata = cpu_wdata;
                cpu_rdy   = 1'b1;
                dma_busy  = 1'b0;
                if (trigger) state_next = HALT;
            end
            HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                state_next = parity ? ALIGN : READ;
`else
                state_next = READ;
`endif
            end
            ALIGN: state_next = READ;
            READ: begin
                bus_addr   = {page, count};
                bus_read   = 1'b1;
                state_next = WRITE;
            end
            WRITE: begin
                bus_addr   = OAM_DATA_ADDR;
                bus_write  = 1'b1;
                bus_wdata  = latch;
                // Last byte: count wraps to 00 on this same edge.
                state_next = (count == 8'hFF) ? IDLE : READ;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
